// File: rtl/iob_native_ram_slave_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : iob_native_ram_slave_pkg
//  Description : Shared FSM encoding, lane count and wait-state limits for
//                the IOb native RAM responder and its RAM macro.
//  Revision    : 1.0  initial release
// ============================================================================
package iob_native_ram_slave_pkg;

   // Bus data width this block is built for, and its byte-lane count
   localparam int c_DATA_W   = 32;
   localparam int c_LANES    = c_DATA_W / 8;

   // Largest legal number of inserted wait states
   localparam int c_WAIT_MAX = 15;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   // Wait counter width; at least one bit so the counter always exists
   function automatic int cnt_width(input int wait_cycles);
      return (wait_cycles > 0) ? $clog2(wait_cycles + 1) : 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/iob_native_ram_sp.sv
`default_nettype none
// ============================================================================
//  Module      : iob_native_ram_sp
//  Description : Single-port RAM with per-byte write enables and a
//                registered read port. Contents are not reset.
//  Revision    : 1.0  initial release
// ============================================================================
module iob_native_ram_sp #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 10
) (
   input  logic                clk,
   input  logic                en,
   input  logic [DATA_W/8-1:0] we,
   input  logic [ADDR_W-1:0]   addr,
   input  logic [DATA_W-1:0]   din,
   output logic [DATA_W-1:0]   dout
);

   logic [DATA_W-1:0] r_mem [2**ADDR_W];

   // Byte-lane writes and read-first registered read on every enabled cycle
   always_ff @(posedge clk) begin
      if (en) begin
         for (int i = 0; i < DATA_W/8; i++) begin
            if (we[i]) begin
               r_mem[addr][i*8 +: 8] <= din[i*8 +: 8];
            end
         end
         dout <= r_mem[addr];
      end
   end

endmodule
`default_nettype wire

// File: rtl/iob_native_ram_slave.sv
`default_nettype none
// ============================================================================
//  Module      : iob_native_ram_slave
//  Description : IOb native bus responder backed by a byte-enabled RAM, with
//                a programmable number of wait states before each response.
//                Optional macro IOB_NATIVE_RAM_ERR_EN adds an err output that
//                flags accesses above the RAM depth instead of aliasing them.
//  Revision    : 1.0  initial release
// ============================================================================
module iob_native_ram_slave
   import iob_native_ram_slave_pkg::*;
#(
   parameter int ADDR_W      = 32,
   parameter int DATA_W      = 32,
   parameter int MEM_ADDR_W  = 10,
   parameter int WAIT_CYCLES = 0
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                valid,
   input  logic [ADDR_W-1:0]   address,
   input  logic [DATA_W-1:0]   wdata,
   input  logic [DATA_W/8-1:0] wstrb,
   output logic [DATA_W-1:0]   rdata,
   output logic                ready
`ifdef IOB_NATIVE_RAM_ERR_EN
   ,
   output logic                err
`endif
);

   localparam int CNT_W  = cnt_width(WAIT_CYCLES);
   localparam int LOAD_I = (WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0;
   localparam logic [CNT_W-1:0] LOAD = LOAD_I[CNT_W-1:0];

   if ((WAIT_CYCLES < 0) || (WAIT_CYCLES > c_WAIT_MAX) || (DATA_W != c_DATA_W)) begin : g_bad_param
      $error("iob_native_ram_slave: unsupported WAIT_CYCLES or DATA_W");
   end

   state_t                r_state, w_next;
   logic [CNT_W-1:0]      r_cnt, w_cnt_next;
   logic [MEM_ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0]     r_wdata;
   logic [DATA_W/8-1:0]   r_wstrb;
   logic                  r_oor;
   logic [DATA_W-1:0]     r_rdata;

   logic                  w_oor_in;
   logic                  w_req_read;
   logic                  w_rd_en;
   logic                  w_wr_en;
   logic [DATA_W/8-1:0]   w_ram_we;
   logic [MEM_ADDR_W-1:0] w_ram_addr;
   logic [DATA_W-1:0]     w_dout;
   logic [DATA_W-1:0]     w_resp_data;
   logic                  w_resp_read;
   logic                  w_err;
   logic                  w_unused_addr;

   // Byte-offset bits (and, without range checking, the upper bits) are don't-care
   assign w_unused_addr = ^address;

`ifdef IOB_NATIVE_RAM_ERR_EN
   assign w_oor_in = |(address >> (MEM_ADDR_W + 2));
   assign err      = w_err;
`else
   assign w_oor_in = 1'b0;
`endif

   // State, counter and latched request fields
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
         r_addr  <= '0;
         r_wdata <= '0;
         r_wstrb <= '0;
         r_oor   <= 1'b0;
      end else begin
         r_state <= w_next;
         r_cnt   <= w_cnt_next;
         if (r_state == ST_IDLE && valid) begin
            r_addr  <= address[MEM_ADDR_W+1:2];
            r_wdata <= wdata;
            r_wstrb <= wstrb;
            r_oor   <= w_oor_in;
         end
      end
   end

   // Next-state, wait countdown and the single-cycle response strobes
   always_comb begin
      w_next     = r_state;
      w_cnt_next = r_cnt;
      ready      = 1'b0;
      w_err      = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (valid) begin
               if (WAIT_CYCLES > 0) begin
                  w_next     = ST_WAIT;
                  w_cnt_next = LOAD;
               end else begin
                  w_next = ST_RESP;
               end
            end
         end
         ST_WAIT: begin
            if (r_cnt == '0) begin
               w_next = ST_RESP;
            end else begin
               w_cnt_next = r_cnt - 1'b1;
            end
         end
         ST_RESP: begin
            ready  = 1'b1;
            w_err  = r_oor;
            w_next = ST_IDLE;
         end
         default: begin
            w_next = ST_IDLE;
         end
      endcase
   end

   // The RAM read is issued on the edge entering RESP so its registered output
   // lines up with ready; writes commit only inside RESP so a reset can never
   // leave a partial write behind.
   assign w_req_read  = (r_state == ST_IDLE) ? ((wstrb == '0) && !w_oor_in)
                                             : ((r_wstrb == '0) && !r_oor);
   assign w_rd_en     = (w_next == ST_RESP) && (r_state != ST_RESP) && w_req_read;
   assign w_wr_en     = (r_state == ST_RESP) && (r_wstrb != '0) && !r_oor;
   assign w_ram_we    = w_wr_en ? r_wstrb : '0;
   assign w_ram_addr  = (r_state == ST_IDLE) ? address[MEM_ADDR_W+1:2] : r_addr;

   iob_native_ram_sp #(
      .DATA_W (DATA_W),
      .ADDR_W (MEM_ADDR_W)
   ) u_ram (
      .clk  (clk),
      .en   (w_rd_en | w_wr_en),
      .we   (w_ram_we),
      .addr (w_ram_addr),
      .din  (r_wdata),
      .dout (w_dout)
   );

   assign w_resp_read = (r_state == ST_RESP) && (r_wstrb == '0);
   assign w_resp_data = r_oor ? '0 : w_dout;

   // Hold the last read response so rdata is stable between reads
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rdata <= '0;
      end else if (w_resp_read) begin
         r_rdata <= w_resp_data;
      end
   end

   assign rdata = w_resp_read ? w_resp_data : r_rdata;

endmodule
`default_nettype wire

// File: tb/tb_iob_native_ram_slave.sv
`default_nettype none
// ============================================================================
//  Module      : tb_iob_native_ram_slave
//  Description : Directed self-checking bench for iob_native_ram_slave with
//                one instance at WAIT_CYCLES=0 and one at WAIT_CYCLES=3.
//                Define IOB_NATIVE_RAM_ERR_EN to also exercise the err port.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_iob_native_ram_slave;

   logic        clk;
   logic        rst0, rst3;
   logic        v0, v3;
   logic [31:0] a0, a3, wd0, wd3, rd0, rd3;
   logic [3:0]  ws0, ws3;
   logic        rdy0, rdy3;
   logic        err0, err3;

   int checks = 0;
   int errors = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   iob_native_ram_slave #(
      .ADDR_W(32), .DATA_W(32), .MEM_ADDR_W(10), .WAIT_CYCLES(0)
   ) u_dut0 (
      .clk(clk), .rst(rst0), .valid(v0), .address(a0), .wdata(wd0),
      .wstrb(ws0), .rdata(rd0), .ready(rdy0)
`ifdef IOB_NATIVE_RAM_ERR_EN
      , .err(err0)
`endif
   );

   iob_native_ram_slave #(
      .ADDR_W(32), .DATA_W(32), .MEM_ADDR_W(10), .WAIT_CYCLES(3)
   ) u_dut3 (
      .clk(clk), .rst(rst3), .valid(v3), .address(a3), .wdata(wd3),
      .wstrb(ws3), .rdata(rd3), .ready(rdy3)
`ifdef IOB_NATIVE_RAM_ERR_EN
      , .err(err3)
`endif
   );

`ifndef IOB_NATIVE_RAM_ERR_EN
   assign err0 = 1'b0;
   assign err3 = 1'b0;
`endif

   // One bus access on instance sel (0 or 3 wait states); lat counts edges from
   // the sampling edge to the ready cycle, -1 if ready never arrives.
   task automatic access(input bit sel, input logic [31:0] addr, input logic [31:0] data,
                         input logic [3:0] strb, input bit hold,
                         output int lat, output logic [31:0] rd, output logic er);
      if (sel) begin v3 = 1'b1; a3 = addr; wd3 = data; ws3 = strb; end
      else     begin v0 = 1'b1; a0 = addr; wd0 = data; ws0 = strb; end
      lat = -1; rd = '0; er = 1'b0;
      for (int n = 1; n <= 20; n++) begin
         @(posedge clk); #1;
         if (sel ? rdy3 : rdy0) begin
            lat = n;
            rd  = sel ? rd3 : rd0;
            er  = sel ? err3 : err0;
            break;
         end
      end
      if (!hold) begin
         if (sel) begin v3 = 1'b0; ws3 = '0; end
         else     begin v0 = 1'b0; ws0 = '0; end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_reset();
      rst0 = 1'b1; rst3 = 1'b1;
      repeat (3) @(posedge clk);
      #1; rst0 = 1'b0; rst3 = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         checks++;
         if (rdy0 !== 1'b0 || rd0 !== 32'h0 || rdy3 !== 1'b0 || rd3 !== 32'h0) begin
            errors++;
            $display("FAIL reset_idle cycle %0d: rdy0=%b rd0=%h rdy3=%b rd3=%h required 0/0", i, rdy0, rd0, rdy3, rd3);
         end
`ifdef IOB_NATIVE_RAM_ERR_EN
         checks++;
         if (err0 !== 1'b0 || err3 !== 1'b0) begin
            errors++;
            $display("FAIL reset_err: err0=%b err3=%b required 0", err0, err3);
         end
`endif
      end
   endtask

   task automatic test_write_read();
      int lat; logic [31:0] rd; logic er;
      access(1'b0, 32'h10, 32'hDEADBEEF, 4'hF, 1'b0, lat, rd, er);
      checks++;
      if (lat !== 1) begin errors++; $display("FAIL wr0_latency: got %0d required 1", lat); end
      checks++;
      if (rd !== 32'h0) begin errors++; $display("FAIL wr0_rdata_hold: got %h required 00000000", rd); end
      access(1'b0, 32'h10, 32'h0, 4'h0, 1'b0, lat, rd, er);
      checks++;
      if (lat !== 1) begin errors++; $display("FAIL rd0_latency: got %0d required 1", lat); end
      checks++;
      if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL rd0_data: got %h required deadbeef", rd); end
   endtask

   task automatic test_byte_strobes();
      int lat; logic [31:0] rd; logic er;
      access(1'b0, 32'h20, 32'h11223344, 4'hF, 1'b0, lat, rd, er);
      access(1'b0, 32'h20, 32'hAABBCCDD, 4'b0101, 1'b0, lat, rd, er);
      checks++;
      if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL strobe_write_rdata_hold: got %h required deadbeef", rd); end
      access(1'b0, 32'h20, 32'h0, 4'h0, 1'b0, lat, rd, er);
      checks++;
      if (rd !== 32'h11BB33DD) begin errors++; $display("FAIL strobe_merge: got %h required 11bb33dd", rd); end
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (rd0 !== 32'h11BB33DD) begin errors++; $display("FAIL rdata_hold_idle: got %h required 11bb33dd", rd0); end
   endtask

   task automatic test_wait_states();
      int lat; logic [31:0] rd; logic er;
      access(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 1'b0, lat, rd, er);
      checks++;
      if (lat !== 4) begin errors++; $display("FAIL wr3_latency: got %0d required 4", lat); end
      access(1'b1, 32'h10, 32'h0, 4'h0, 1'b0, lat, rd, er);
      checks++;
      if (lat !== 4) begin errors++; $display("FAIL rd3_latency: got %0d required 4", lat); end
      checks++;
      if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL rd3_data: got %h required deadbeef", rd); end
   endtask

   task automatic test_back_to_back();
      int lat; int lat2; logic [31:0] rd; logic er;
      access(1'b1, 32'h10, 32'h0, 4'h0, 1'b1, lat, rd, er);
      checks++;
      if (lat !== 4) begin errors++; $display("FAIL b2b_first_latency: got %0d required 4", lat); end
      lat2 = -1;
      for (int n = 1; n <= 20; n++) begin
         @(posedge clk); #1;
         if (n == 1) begin
            checks++;
            if (rdy3 !== 1'b0) begin errors++; $display("FAIL ready_pulse_width: ready=%b required 0", rdy3); end
         end
         if (rdy3) begin lat2 = n; break; end
      end
      v3 = 1'b0;
      checks++;
      if (lat2 !== 5) begin errors++; $display("FAIL b2b_second_spacing: got %0d required 5", lat2); end
      checks++;
      if (rd3 !== 32'hDEADBEEF) begin errors++; $display("FAIL b2b_second_data: got %h required deadbeef", rd3); end
      @(posedge clk); #1;
   endtask

   task automatic test_valid_drop();
      int lat; logic [31:0] rd; logic er;
      v3 = 1'b1; a3 = 32'h40; wd3 = 32'hCAFEF00D; ws3 = 4'hF;
      @(posedge clk); #1;
      v3 = 1'b0; a3 = '0; wd3 = '0; ws3 = '0;
      lat = -1;
      for (int n = 2; n <= 12; n++) begin
         @(posedge clk); #1;
         if (rdy3) begin lat = n; break; end
      end
      checks++;
      if (lat !== 4) begin errors++; $display("FAIL valid_drop_ready: got %0d required 4", lat); end
      @(posedge clk); #1;
      access(1'b1, 32'h40, 32'h0, 4'h0, 1'b0, lat, rd, er);
      checks++;
      if (rd !== 32'hCAFEF00D) begin errors++; $display("FAIL valid_drop_data: got %h required cafef00d", rd); end
   endtask

   task automatic test_reset_mid_access();
      int lat; logic [31:0] rd; logic er; logic seen;
      access(1'b1, 32'h30, 32'h12345678, 4'hF, 1'b0, lat, rd, er);
      v3 = 1'b1; a3 = 32'h30; wd3 = 32'h55; ws3 = 4'hF;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst3 = 1'b1; v3 = 1'b0; ws3 = '0; wd3 = '0;
      seen = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         if (rdy3) seen = 1'b1;
      end
      checks++;
      if (seen !== 1'b0) begin errors++; $display("FAIL abort_no_ready: ready seen=%b required 0", seen); end
      checks++;
      if (rd3 !== 32'h0) begin errors++; $display("FAIL abort_rdata_reset: got %h required 00000000", rd3); end
      rst3 = 1'b0;
      @(posedge clk); #1;
      access(1'b1, 32'h30, 32'h0, 4'h0, 1'b0, lat, rd, er);
      checks++;
      if (lat !== 4) begin errors++; $display("FAIL abort_read_latency: got %0d required 4", lat); end
      checks++;
      if (rd !== 32'h12345678) begin errors++; $display("FAIL abort_no_partial_write: got %h required 12345678", rd); end
   endtask

`ifdef IOB_NATIVE_RAM_ERR_EN
   task automatic test_err();
      int lat; logic [31:0] rd; logic er;
      access(1'b0, 32'h0000_1000, 32'h0, 4'h0, 1'b0, lat, rd, er);
      checks++;
      if (lat !== 1) begin errors++; $display("FAIL err_latency: got %0d required 1", lat); end
      checks++;
      if (er !== 1'b1) begin errors++; $display("FAIL err_flag_oor: got %b required 1", er); end
      checks++;
      if (rd !== 32'h0) begin errors++; $display("FAIL err_rdata_zero: got %h required 00000000", rd); end
      access(1'b0, 32'h0000_0010, 32'h0, 4'h0, 1'b0, lat, rd, er);
      checks++;
      if (er !== 1'b0) begin errors++; $display("FAIL err_flag_inrange: got %b required 0", er); end
      checks++;
      if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL err_inrange_data: got %h required deadbeef", rd); end
   endtask
`endif

   initial begin
      rst0 = 1'b1; rst3 = 1'b1;
      v0 = 1'b0; a0 = '0; wd0 = '0; ws0 = '0;
      v3 = 1'b0; a3 = '0; wd3 = '0; ws3 = '0;
      test_reset();
      test_write_read();
      test_byte_strobes();
      test_wait_states();
      test_back_to_back();
      test_valid_drop();
      test_reset_mid_access();
`ifdef IOB_NATIVE_RAM_ERR_EN
      test_err();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/iob_native_ram_slave.md
Name: iob_native_ram_slave

Overview:
- Responder (slave) end of the IOb native memory bus: valid/address/wdata/wstrb in, rdata/ready out.
- Sits behind one slave port of the split demux, e.g. on ibus or dbus, and serves CPU fetches and loads/stores from an internal byte-enabled single-port RAM.
- A programmable wait-state counter models slow memory, so the CPU wrapper and interconnect can be exercised with non-zero latency.

Parameters:
- ADDR_W, 32, bus byte-address width.
- DATA_W, 32, bus data width; fixed at 32 for this block; byte lanes = DATA_W/8 = 4.
- MEM_ADDR_W, 10, RAM word-address width; depth = 2**MEM_ADDR_W words.
- WAIT_CYCLES, 0, extra cycles inserted between request accept and ready (0..15).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- valid  in  1  request valid; master holds it and all request fields stable until ready.
- address  in  ADDR_W  byte address; bits [1:0] are ignored.
- wdata  in  DATA_W  write data.
- wstrb  in  DATA_W/8  byte write enables; all zero means read.
- rdata  out  DATA_W  read data; valid in the cycle ready=1.
- ready  out  1  one-cycle response pulse.

Behaviour:
- Reset (async, rst=1): FSM to IDLE, wait counter 0, ready=0, rdata=0. RAM contents are not reset.
- FSM states: IDLE, WAIT, RESP.
  - IDLE: if valid=1, latch address word index, wdata and wstrb. Go to WAIT if WAIT_CYCLES>0 (counter loaded with WAIT_CYCLES-1), otherwise go to RESP.
  - WAIT: decrement the counter; when it is 0, go to RESP.
  - RESP: perform the access using the latched fields, assert ready for exactly 1 cycle, then go to IDLE.
- Latency: valid sampled at edge t, ready high during cycle t+1+WAIT_CYCLES.
- Back-to-back requests: after the ready cycle the FSM is in IDLE. A valid still high on the next edge is treated as a new request. Minimum spacing is 2 cycles per access.
- RAM word index = address[MEM_ADDR_W+1:2].
- Write (wstrb≠0): only the lanes with wstrb[i]=1 are updated in the RESP cycle. rdata holds its previous value.
- Read (wstrb=0): rdata is loaded from RAM, registered, and presented in the ready cycle. rdata holds that value until the next read response.
- valid dropped while in WAIT (protocol violation): the latched access still completes and ready still pulses. No abort.
- valid changing in RESP is ignored.
- Counter width is $clog2(WAIT_CYCLES+1), minimum 1 bit.
- rst asserted mid-access: the access is dropped; no partial write, because writes happen only in RESP.

Optional Feature:
- Macro: IOB_NATIVE_RAM_ERR_EN.
- Defined:
  - Extra output port err (1 bit, reset 0).
  - An access with any address[ADDR_W-1:MEM_ADDR_W+2] ≠ 0 is out of range: no RAM write, rdata driven 0, ready pulses with normal latency, and err=1 in the same cycle as ready.
  - err is 0 at all other times.
- Undefined: no err port; upper address bits are ignored, so accesses alias modulo the RAM depth.

Decomposition:
- Shared header iob_native_ram.vh holds:
  - FSM state encodings (IDLE=2'd0, WAIT=2'd1, RESP=2'd2).
  - Lane-count constant DATA_W/8.
  - WAIT_CYCLES legal-range check constant.
- One sub-module, iob_native_ram_sp: single-port RAM with byte write enables and a registered read port (ports clk, en, we[DATA_W/8], addr, din, dout). The top holds the FSM, counter and response logic.

Test Plan:
- Reset and idle: rst=1 for 3 cycles, then 0 with valid=0 for 10 cycles -> ready=0 and rdata=0 throughout.
- Write/read, WAIT_CYCLES=0: write 0xDEADBEEF to 0x10 with wstrb=4'hF, then read 0x10 -> each ready lands 1 cycle after valid is sampled; read returns 0xDEADBEEF.
- Byte strobes: write 0x11223344 to 0x20 with wstrb=4'hF, then write 0xAABBCCDD with wstrb=4'b0101, then read -> 0x11BB33DD.
- Wait states, WAIT_CYCLES=3: read 0x10 -> ready exactly 4 cycles after valid is sampled; ready is high for 1 cycle only; valid held high across ready starts a second access and a second ready arrives 5 cycles later.
- Reset mid-access, WAIT_CYCLES=3: issue a write of 0x55 to 0x30, assert rst during WAIT, then read 0x30 after reset -> no ready for the aborted write; read returns the pre-existing value.
- IOB_NATIVE_RAM_ERR_EN with MEM_ADDR_W=10: read 0x0000_1000 -> ready=1, err=1, rdata=0. Read 0x0000_0010 -> err=0 and the correct data is returned.
